ee_word_packer: RTL and testbench

- Byte-to-word access sequencer between the serial host interface and the ECC/test mux stage.
- Write path: packs host bytes into 32-bit words and performs read-modify-write for partial words. It drives wr_roll_over when a page write wraps.
- Read path: fetches 38-bit words and streams bytes back to the host.
- One EEPROM word access is outstanding at any time.

---
 rtl/ee_pkg.sv | 37 +++
 rtl/ee_word_packer_if.sv | 38 +++
 rtl/ee_byte_lane_merge.sv | 15 +
 rtl/ee_word_packer.sv | 168 ++++++++++++++++
 tb/tb_ee_word_packer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ee_pkg.sv
// Shared types and helpers for the EEPROM byte/word access sequencer.
// Little-endian lane helpers: offset k lives in word[8k+7:8k].
package ee_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WFILL,
    WRMW_RD,
    WRMW_WR,
    WWR,
    RFETCH,
    RSEND
  } state_t;

  localparam logic [5:0] ERASE_ECC = 6'h3f;

  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    res[{off, 3'b000} +: 8] = data;
    return res;
  endfunction

  // Lanes with a set mask bit keep the packed host byte, others take the fetched byte.
  function automatic logic [31:0] merge_lanes(input logic [31:0] packed_word,
                                              input logic [3:0]  mask,
                                              input logic [31:0] fetched);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? packed_word[8*i +: 8] : fetched[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ee_word_packer_if.sv
// Host byte stream and EEPROM word access bundle of the word packer.
// slave is the packer's view, master the host/EEPROM side.
interface ee_word_packer_if #(
  parameter int ADDR_W = 12
);
  logic              wr_start;
  logic              rd_start;
  logic [ADDR_W-1:0] start_addr;
  logic              xfer_stop;
  logic              wr_byte_vld;
  logic [7:0]        wr_byte;
  logic              wr_byte_rdy;
  logic              rd_byte_vld;
  logic [7:0]        rd_byte;
  logic              rd_byte_rdy;
  logic [ADDR_W-3:0] ee_word_addr;
  logic              ee_wr_req;
  logic              ee_rd_req;
  logic              ee_ack;
  logic [37:0]       if_data_out;
  logic [37:0]       if_data_in;
  logic              wr_roll_over;

  modport slave (
    input  wr_start, rd_start, start_addr, xfer_stop, wr_byte_vld, wr_byte,
           rd_byte_rdy, ee_ack, if_data_in,
    output wr_byte_rdy, rd_byte_vld, rd_byte, ee_word_addr, ee_wr_req,
           ee_rd_req, if_data_out, wr_roll_over
  );

  modport master (
    output wr_start, rd_start, start_addr, xfer_stop, wr_byte_vld, wr_byte,
           rd_byte_rdy, ee_ack, if_data_in,
    input  wr_byte_rdy, rd_byte_vld, rd_byte, ee_word_addr, ee_wr_req,
           ee_rd_req, if_data_out, wr_roll_over
  );

endinterface

// File: rtl/ee_byte_lane_merge.sv
// Combinational read-modify-write merge of the packing register with a fetched word.
module ee_byte_lane_merge
  import ee_pkg::*;
(
  input  logic [31:0] packed_word,
  input  logic [3:0]  mask,
  input  logic [31:0] fetched,
  output logic [31:0] merged
);

  always_comb begin
    merged = merge_lanes(packed_word, mask, fetched);
  end

endmodule

// File: rtl/ee_word_packer.sv
// Byte-to-word access sequencer: packs host bytes into EEPROM words (with RMW
// for partial words and page roll-over) and streams fetched words back as bytes.
module ee_word_packer
  import ee_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int PAGE_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst,
  ee_word_packer_if.slave   bus
);

  localparam int LOG_PB = $clog2(PAGE_BYTES);
  localparam logic [LOG_PB-1:0] PG_ONE   = {{(LOG_PB-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       pack;
  logic [3:0]        mask;
  logic              wrapped;
  logic              stop_seen;
  logic [31:0]       rd_word;
  logic [ADDR_W-3:0] word_addr_q;
  logic [37:0]       data_out_q;
  logic              roll_q;

  logic              byte_take;
  logic [31:0]       pack_fill;
  logic [3:0]        mask_fill;
  logic [LOG_PB-1:0] page_low_inc;
  logic [ADDR_W-1:0] addr_page;
  logic [ADDR_W-1:0] addr_inc;
  logic              page_end;
  logic [31:0]       merged;
  logic              unused_ecc;

  assign unused_ecc = ^bus.if_data_in[37:32];

  ee_byte_lane_merge u_merge (
    .packed_word (pack),
    .mask        (mask),
    .fetched     (bus.if_data_in[31:0]),
    .merged      (merged)
  );

  assign byte_take    = (state == WFILL) && bus.wr_byte_vld;
  assign pack_fill    = insert_byte(pack, addr[1:0], bus.wr_byte);
  assign mask_fill    = mask | (4'b0001 << addr[1:0]);
  assign page_low_inc = addr[LOG_PB-1:0] + PG_ONE;
  assign addr_page    = {addr[ADDR_W-1:LOG_PB], page_low_inc};
  assign addr_inc     = addr + ADDR_ONE;
  assign page_end     = &addr[LOG_PB-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.wr_start)      state_next = WFILL;
        else if (bus.rd_start) state_next = RFETCH;
      end
      WFILL: begin
        // A byte in the same cycle as stop is packed before the stop takes effect.
        if (byte_take) begin
          if (addr_page[1:0] == 2'd0) state_next = (&mask_fill) ? WWR : WRMW_RD;
          else if (bus.xfer_stop)     state_next = WRMW_RD;
        end else if (bus.xfer_stop) begin
          state_next = (mask == 4'h0) ? IDLE : WRMW_RD;
        end
      end
      WRMW_RD: begin
        if (bus.ee_ack) state_next = WRMW_WR;
      end
      WWR, WRMW_WR: begin
        if (bus.ee_ack) state_next = (stop_seen || bus.xfer_stop) ? IDLE : WFILL;
      end
      RFETCH: begin
        if (bus.ee_ack) state_next = (stop_seen || bus.xfer_stop) ? IDLE : RSEND;
      end
      RSEND: begin
        if (bus.xfer_stop)                                  state_next = IDLE;
        else if (bus.rd_byte_rdy && addr_inc[1:0] == 2'd0) state_next = RFETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      pack        <= '0;
      mask        <= '0;
      wrapped     <= 1'b0;
      stop_seen   <= 1'b0;
      rd_word     <= '0;
      word_addr_q <= '0;
      data_out_q  <= {ERASE_ECC, 32'h0};
      roll_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_seen <= 1'b0;
          if (bus.wr_start) begin
            addr    <= bus.start_addr;
            mask    <= '0;
            wrapped <= 1'b0;
          end else if (bus.rd_start) begin
            addr        <= bus.start_addr;
            word_addr_q <= bus.start_addr[ADDR_W-1:2];
          end
        end
        WFILL: begin
          if (bus.xfer_stop) stop_seen <= 1'b1;
          if (byte_take) begin
            pack <= pack_fill;
            mask <= mask_fill;
            addr <= addr_page;
            if (page_end) wrapped <= 1'b1;
          end
          // The finished word is addressed before the increment; its page state is pre-crossing.
          if (state_next == WWR || state_next == WRMW_RD) begin
            word_addr_q <= addr[ADDR_W-1:2];
            roll_q      <= wrapped;
            data_out_q  <= {ERASE_ECC, byte_take ? pack_fill : pack};
          end
        end
        WRMW_RD: begin
          if (bus.xfer_stop) stop_seen <= 1'b1;
          if (bus.ee_ack) begin
            pack       <= merged;
            data_out_q <= {ERASE_ECC, merged};
          end
        end
        WWR, WRMW_WR: begin
          if (bus.xfer_stop) stop_seen <= 1'b1;
          if (bus.ee_ack)    mask <= '0;
        end
        RFETCH: begin
          if (bus.xfer_stop) stop_seen <= 1'b1;
          if (bus.ee_ack)    rd_word <= bus.if_data_in[31:0];
        end
        RSEND: begin
          if (bus.rd_byte_rdy) begin
            addr <= addr_inc;
            if (addr_inc[1:0] == 2'd0) word_addr_q <= addr_inc[ADDR_W-1:2];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_byte_rdy  = (state == WFILL);
  assign bus.rd_byte_vld  = (state == RSEND);
  assign bus.rd_byte      = rd_word[{addr[1:0], 3'b000} +: 8];
  assign bus.ee_wr_req    = (state == WWR) || (state == WRMW_WR);
  assign bus.ee_rd_req    = (state == WRMW_RD) || (state == RFETCH);
  assign bus.ee_word_addr = word_addr_q;
  assign bus.if_data_out  = data_out_q;
  assign bus.wr_roll_over = roll_q;

endmodule

// File: tb/tb_ee_word_packer.sv
// Scoreboard bench for ee_word_packer: an EEPROM responder checks word writes and
// serves fetches from queues, a host monitor checks streamed read bytes.
module tb_ee_word_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ee_word_packer_if #(.ADDR_W(12)) bus ();

  ee_word_packer #(.ADDR_W(12), .PAGE_BYTES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [37:0] data;
    logic        roll;
  } wr_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } rd_t;

  wr_t        wr_exp[$];
  rd_t        fetch_q[$];
  logic [7:0] rd_exp[$];

  int checks   = 0;
  int failures = 0;
  bit resp_en  = 1'b1;
  bit late_ack = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // EEPROM responder: acks each request on its second cycle.
  initial begin
    int   age = 0;
    wr_t  w;
    rd_t  r;
    logic [63:0] ea, ed, er;
    bus.ee_ack     = 1'b0;
    bus.if_data_in = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.ee_ack) begin
        bus.ee_ack = 1'b0;
        age        = 0;
      end else if (late_ack) begin
        bus.ee_ack = 1'b1;
        late_ack   = 1'b0;
      end else if (resp_en && (bus.ee_wr_req || bus.ee_rd_req)) begin
        age++;
        if (age >= 2) begin
          bus.ee_ack = 1'b1;
          ea = '1; ed = '1; er = '1;
          if (bus.ee_wr_req) begin
            if (wr_exp.size() > 0) begin
              w  = wr_exp.pop_front();
              ea = 64'(w.addr); ed = 64'(w.data); er = 64'(w.roll);
            end
            check("wr_addr", 64'(bus.ee_word_addr), ea);
            check("wr_data", 64'(bus.if_data_out), ed);
            check("wr_roll", 64'(bus.wr_roll_over), er);
          end else begin
            if (fetch_q.size() > 0) begin
              r  = fetch_q.pop_front();
              ea = 64'(r.addr);
              bus.if_data_in = {6'h15, r.data};
            end
            check("rd_addr", 64'(bus.ee_word_addr), ea);
          end
        end
      end else begin
        age = 0;
      end
    end
  end

  // Host read side: random stalls only while bytes are still expected.
  initial begin
    bus.rd_byte_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rd_byte_rdy = (rd_exp.size() > 0) && ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (bus.rd_byte_vld && bus.rd_byte_rdy) begin
        e = (rd_exp.size() > 0) ? 64'(rd_exp.pop_front()) : '1;
        check("rd_byte", 64'(bus.rd_byte), e);
      end
    end
  end

  task automatic start_xfer(input logic w, input logic r, input logic [11:0] a);
    bus.wr_start   = w;
    bus.rd_start   = r;
    bus.start_addr = a;
    @(posedge clk); #1;
    bus.wr_start = 1'b0;
    bus.rd_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit done = 1'b0;
    bus.wr_byte_vld = 1'b1;
    bus.wr_byte     = b;
    bus.xfer_stop   = stop;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.wr_byte_rdy) done = 1'b1;
      @(posedge clk); #1;
    end
    bus.wr_byte_vld = 1'b0;
    bus.xfer_stop   = 1'b0;
    check("byte_accept", 64'(done), 64'd1);
  endtask

  task automatic stop_pulse();
    bus.xfer_stop = 1'b1;
    @(posedge clk); #1;
    bus.xfer_stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    bit ok    = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!bus.wr_byte_rdy && !bus.rd_byte_vld && !bus.ee_wr_req && !bus.ee_rd_req) quiet++;
      else quiet = 0;
      if (quiet >= 4) ok = 1'b1;
    end
    check(tag, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_rdy"}, 64'(bus.wr_byte_rdy), 64'd0);
    check({tag, "_rd_vld"}, 64'(bus.rd_byte_vld), 64'd0);
    check({tag, "_rd_byte"}, 64'(bus.rd_byte), 64'd0);
    check({tag, "_wr_req"}, 64'(bus.ee_wr_req), 64'd0);
    check({tag, "_rd_req"}, 64'(bus.ee_rd_req), 64'd0);
    check({tag, "_waddr"}, 64'(bus.ee_word_addr), 64'd0);
    check({tag, "_dout"}, 64'(bus.if_data_out), 64'h3f_0000_0000);
    check({tag, "_roll"}, 64'(bus.wr_roll_over), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.wr_start    = 1'b0;
    bus.rd_start    = 1'b0;
    bus.start_addr  = '0;
    bus.xfer_stop   = 1'b0;
    bus.wr_byte_vld = 1'b0;
    bus.wr_byte     = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Aligned full-word write; request must follow the 4th byte immediately.
    wr_exp.push_back('{addr: 10'h004, data: 38'h3f_4433_2211, roll: 1'b0});
    start_xfer(1'b1, 1'b0, 12'h010);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    check("wr_latency", 64'(bus.ee_wr_req), 64'd1);
    stop_pulse();
    wait_idle("idle_aligned");

    // Partial write via read-modify-write.
    fetch_q.push_back('{addr: 10'h008, data: 32'h1234_5678});
    wr_exp.push_back('{addr: 10'h008, data: 38'h3f_12BB_AA78, roll: 1'b0});
    start_xfer(1'b1, 1'b0, 12'h021);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    stop_pulse();
    wait_idle("idle_partial");

    // Page roll-over: second word wraps back to the page start.
    wr_exp.push_back('{addr: 10'h007, data: 38'h3f_0403_0201, roll: 1'b0});
    wr_exp.push_back('{addr: 10'h004, data: 38'h3f_0807_0605, roll: 1'b1});
    start_xfer(1'b1, 1'b0, 12'h01C);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    stop_pulse();
    wait_idle("idle_roll");

    // Read stream across a word boundary with random host stalls.
    fetch_q.push_back('{addr: 10'h03F, data: 32'hA1B2_C3D4});
    fetch_q.push_back('{addr: 10'h040, data: 32'h0506_0708});
    rd_exp.push_back(8'hB2);
    rd_exp.push_back(8'hA1);
    rd_exp.push_back(8'h08);
    rd_exp.push_back(8'h07);
    start_xfer(1'b0, 1'b1, 12'h0FE);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.ee_ack && bus.ee_rd_req) seen = 1'b1;
    end
    check("rd_ack_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("rd_latency", 64'(bus.rd_byte_vld), 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 300 && rd_exp.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check("rd_bytes_left", 64'(rd_exp.size()), 64'd0);
    stop_pulse();
    wait_idle("idle_read");

    // Reset while a RMW fetch is pending, then a stray late ack.
    resp_en = 1'b0;
    start_xfer(1'b1, 1'b0, 12'h031);
    send_byte(8'h5A, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.ee_rd_req) seen = 1'b1;
    end
    check("rmw_req_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    late_ack = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("post_reset");
    end
    @(posedge clk); #1;
    resp_en = 1'b1;

    // Simultaneous starts (write wins) and last byte arriving with stop.
    fetch_q.push_back('{addr: 10'h011, data: 32'hCAFE_F00D});
    wr_exp.push_back('{addr: 10'h011, data: 38'h3f_CAFE_9B9A, roll: 1'b0});
    start_xfer(1'b1, 1'b1, 12'h044);
    send_byte(8'h9A, 1'b0);
    send_byte(8'h9B, 1'b1);
    wait_idle("idle_both");

    check("wr_queue_left", 64'(wr_exp.size()), 64'd0);
    check("fetch_queue_left", 64'(fetch_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
